// File: rtl/gf180mcu_osu_sc_gp9t3v3__ro_mon_ctrl.sv
// ---------------------------------------------------------------------------
// gf180mcu_osu_sc_gp9t3v3__ro_mon_ctrl
//
// Sequencer for the inverter ring-oscillator process monitor. On START it
// enables the ring, waits SETTLE cycles for it to stabilise, counts rising
// edges of the (pre-divided) ring output for WIN_LEN cycles, then disables
// the ring and publishes the count with a one-cycle DONE pulse.
//
// Ports
//   CLK      in   sole clock, rising edge
//   RST      in   asynchronous active-high reset
//   START    in   measurement request, honoured only in IDLE
//   WIN_LEN  in   window length in CLK cycles, latched on START
//   RO_OUT   in   divided ring output, asynchronous to CLK (< CLK/2)
//   RO_EN    out  ring enable (SETTLE + MEASURE)
//   BUSY     out  high in SETTLE + MEASURE
//   DONE     out  one-cycle result-valid pulse
//   COUNT    out  last edge count, held until the next DONE
//   OVF      out  last count saturated, held with COUNT
// ---------------------------------------------------------------------------
module gf180mcu_osu_sc_gp9t3v3__ro_mon_ctrl #(
    parameter int WIN_W  = 16,
    parameter int CNT_W  = 16,
    parameter int SETTLE = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIN_W-1:0] WIN_LEN,
    input  logic             RO_OUT,
    output logic             RO_EN,
    output logic             BUSY,
    output logic             DONE,
    output logic [CNT_W-1:0] COUNT,
    output logic             OVF
);

    // One timer serves both the settle and measure phases, so it must hold
    // whichever of the two terminal values is wider.
    localparam int SET_W = $clog2(SETTLE + 1);
    localparam int TMR_W = (WIN_W > SET_W) ? WIN_W : SET_W;
    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETTLE  = 2'd1,
        S_MEASURE = 2'd2,
        S_REPORT  = 2'd3
    } state_t;

    state_t             state_q;
    logic [WIN_W-1:0]   win_q;
    logic [TMR_W-1:0]   tmr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               sat_q;
    logic               s1_q, s2_q, s3_q;
    logic               ro_en_q, busy_q, done_q, ovf_q;
    logic [CNT_W-1:0]   count_q;

    logic               rise;
    logic [CNT_W-1:0]   cnt_d;
    logic               sat_d;
    logic [TMR_W-1:0]   win_last;

    // Edge detect after the synchronizer; the window boundary lives here.
    assign rise     = s2_q & ~s3_q;
    assign win_last = TMR_W'(win_q) - TMR_W'(1);

    // Saturating edge count for the current MEASURE cycle.
    always_comb begin
        cnt_d = cnt_q;
        sat_d = sat_q;
        if (rise) begin
            if (cnt_q == {CNT_W{1'b1}}) sat_d = 1'b1;
            else                         cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            win_q   <= '0;
            tmr_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
            ro_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            // Synchronizer free-runs so MEASURE entry never sees a stale edge.
            s1_q   <= RO_OUT;
            s2_q   <= s1_q;
            s3_q   <= s2_q;
            done_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (START) begin
                        win_q <= WIN_LEN;
                        tmr_q <= '0;
                        if (WIN_LEN == '0) begin
                            // Empty window: report zero without touching the ring.
                            state_q <= S_REPORT;
                            done_q  <= 1'b1;
                            count_q <= '0;
                            ovf_q   <= 1'b0;
                        end else begin
                            state_q <= S_SETTLE;
                            ro_en_q <= 1'b1;
                            busy_q  <= 1'b1;
                        end
                    end
                end

                S_SETTLE: begin
                    if (tmr_q == SETTLE_LAST) begin
                        state_q <= S_MEASURE;
                        tmr_q   <= '0;
                        cnt_q   <= '0;
                        sat_q   <= 1'b0;
                    end else begin
                        tmr_q <= tmr_q + TMR_W'(1);
                    end
                end

                S_MEASURE: begin
                    cnt_q <= cnt_d;
                    sat_q <= sat_d;
                    if (tmr_q == win_last) begin
                        // Publish including the edge seen in the last window cycle.
                        state_q <= S_REPORT;
                        ro_en_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        count_q <= cnt_d;
                        ovf_q   <= sat_d;
                    end else begin
                        tmr_q <= tmr_q + TMR_W'(1);
                    end
                end

                S_REPORT: begin
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                    ro_en_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign RO_EN = ro_en_q;
    assign BUSY  = busy_q;
    assign DONE  = done_q;
    assign COUNT = count_q;
    assign OVF   = ovf_q;

endmodule
